// File: rtl/s_link_pkg.sv
// ============================================================================
// s_link_pkg : constants and state encoding shared by the S1/S2 serial link
// Rev 1.0
// ============================================================================
`default_nettype none

package s_link_pkg;

    localparam int AW        = 3;
    localparam int DW        = 18;
    localparam int NWORDS    = 8;
    localparam int FRAME_LEN = AW + DW;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_LOAD = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } link_state_t;

endpackage

`default_nettype wire

// File: rtl/s1_serial_tx_if.sv
// ============================================================================
// s1_serial_tx_if : RB1 read port, start/done handshake and sen/sd link
// Rev 1.0
// ============================================================================
`default_nettype none

interface s1_serial_tx_if #(
    parameter int AW = s_link_pkg::AW,
    parameter int DW = s_link_pkg::DW
) ();
    logic          start;
    logic [DW-1:0] RB1_Q;
    logic          RB1_RW;
    logic [AW-1:0] RB1_A;
    logic          sen;
    logic          sd;
    logic          S1_done;

    modport master (
        input  start, RB1_Q,
        output RB1_RW, RB1_A, sen, sd, S1_done
    );

    modport slave (
        output start, RB1_Q,
        input  RB1_RW, RB1_A, sen, sd, S1_done
    );
endinterface

`default_nettype wire

// File: rtl/s1_serial_tx_piso_shift.sv
// ============================================================================
// piso_shift : parallel-load shift register, MSB-first serial output
// Rev 1.0
// ============================================================================
`default_nettype none

module piso_shift #(
    parameter int WIDTH = 21
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load,
    input  wire logic             shift,
    input  wire logic [WIDTH-1:0] par_in,
    output logic                  ser_out
);

    logic [WIDTH-1:0] frame_q;
    logic [WIDTH-1:0] frame_d;

    always_comb begin
        frame_d = frame_q;
        if (load) begin
            frame_d = par_in;
        end else if (shift) begin
            frame_d = {frame_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end

    assign ser_out = frame_q[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/s1_serial_tx.sv
// ============================================================================
// s1_serial_tx : reads RB1 words 0..NWORDS-1 and sends each as an addr+data
//                frame on sen/sd, then pulses S1_done. Rev 1.0
// ============================================================================
`default_nettype none

module s1_serial_tx
    import s_link_pkg::*;
#(
    parameter int AW     = s_link_pkg::AW,
    parameter int DW     = s_link_pkg::DW,
    parameter int NWORDS = s_link_pkg::NWORDS
) (
    input  wire logic       clk,
    input  wire logic       rst,
    s1_serial_tx_if.master  bus
);

    localparam int FLEN = AW + DW;

    link_state_t   state_q, state_d;
    logic [AW-1:0] k_q, k_d;
    logic [4:0]    n_q, n_d;
    logic          load;
    logic          shift;
    logic          frame_msb;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_READ;
                    k_d     = '0;
                end
            end
            ST_READ: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                load    = 1'b1;
                n_d     = '0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                shift = 1'b1;
                n_d   = n_q + 5'd1;
                if (n_q == 5'(FLEN - 1)) begin
                    if (k_q == AW'(NWORDS - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        k_d     = k_q + AW'(1);
                        state_d = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
        end
    end

    // RB1_Q presented during LOAD belongs to address k issued in READ
    piso_shift #(
        .WIDTH (FLEN)
    ) u_piso (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .shift   (shift),
        .par_in  ({k_q, bus.RB1_Q}),
        .ser_out (frame_msb)
    );

    assign bus.RB1_RW  = 1'b1;
    assign bus.RB1_A   = ((state_q == ST_READ) || (state_q == ST_LOAD)) ? k_q : '0;
    assign bus.sen     = (state_q != ST_SEND);
    assign bus.sd      = (state_q == ST_SEND) ? frame_msb : 1'b0;
    assign bus.S1_done = (state_q == ST_DONE);

endmodule

`default_nettype wire
